// File: rtl/adc_ocram_reader_if.sv
// Read-side bus of the ADC capture RAM reader: the shared RAM read port plus
// the outgoing word stream towards the HPS/transmit path.
interface adc_ocram_reader_if #(
    parameter int ADDR_W = 13
);
    // Stream: a word moves when oValid && iReady in the same cycle; while
    // oValid is high and iReady low, oData/oSOP/oEOP are held unchanged.
    logic                oRDEN;
    logic [ADDR_W-1:0]   oRAddr;
    logic [2:0][31:0]    iRAMData;
    logic [31:0]         oData;
    logic                oValid;
    logic                iReady;
    logic                oSOP;
    logic                oEOP;

    modport master (
        output oRDEN, oRAddr, oData, oValid, oSOP, oEOP,
        input  iRAMData, iReady
    );

    modport slave (
        input  oRDEN, oRAddr, oData, oValid, oSOP, oEOP,
        output iRAMData, iReady
    );
endinterface

// File: rtl/adc_ocram_reader.sv
// Reads the three packed capture banks from address 0 to the recorded length
// and streams each address as three 32-bit words, then re-arms the writer.
module adc_ocram_reader #(
    parameter int ADDR_W = 13,
    parameter int RD_LAT = 2,
    parameter int CNT_W  = 15
) (
    input  logic                ocramCLK,
    input  logic                iReset,
    input  logic                iTransmitReady,
    input  logic [ADDR_W-1:0]   iRecLength,
    input  logic                iAbort,
    adc_ocram_reader_if.master  bus,
    output logic                oBusy,
    output logic                oStateReset,
    output logic [CNT_W-1:0]    oWordCount,
    output logic [2:0]          dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_SEND  = 3'd3,
        S_DONE  = 3'd4,
        S_HOLD  = 3'd5
    } state_t;

    state_t            state, state_nxt;
    logic              tr_prev;
    logic              tr_rise;
    logic              xfer;
    logic              at_last;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] last_addr;
    logic [2:0][31:0]  hold;
    logic [1:0]        bank;
    logic [2:0]        lat_cnt;

    // tr_prev resets high so a level already present at reset release is not an edge.
    assign tr_rise = iTransmitReady && !tr_prev;
    assign xfer    = (state == S_SEND) && bus.iReady;
    assign at_last = (addr == last_addr);

    always_ff @(posedge ocramCLK or posedge iReset) begin
        if (iReset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (tr_rise) state_nxt = S_FETCH;
            S_FETCH: state_nxt = iAbort ? S_DONE : S_WAIT;
            S_WAIT: begin
                if (iAbort)                 state_nxt = S_DONE;
                else if (lat_cnt == 3'd1)   state_nxt = S_SEND;
            end
            S_SEND: begin
                if (iAbort)                         state_nxt = S_DONE;
                else if (xfer && bank == 2'd2)      state_nxt = at_last ? S_DONE : S_FETCH;
            end
            S_DONE:  state_nxt = S_HOLD;
            S_HOLD:  if (!iTransmitReady) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge ocramCLK or posedge iReset) begin
        if (iReset) begin
            tr_prev    <= 1'b1;
            addr       <= '0;
            last_addr  <= '0;
            hold       <= '0;
            bank       <= '0;
            lat_cnt    <= '0;
            oWordCount <= '0;
        end else begin
            tr_prev <= iTransmitReady;
            case (state)
                S_IDLE: if (tr_rise) begin
                    last_addr  <= iRecLength;
                    addr       <= '0;
                    bank       <= '0;
                    oWordCount <= '0;
                end
                S_FETCH: lat_cnt <= 3'(RD_LAT);
                S_WAIT: begin
                    lat_cnt <= lat_cnt - 3'd1;
                    if (lat_cnt == 3'd1) begin
                        hold <= bus.iRAMData;
                        bank <= '0;
                    end
                end
                S_SEND: if (xfer) begin
                    oWordCount <= oWordCount + CNT_W'(1);
                    if (bank == 2'd2) begin
                        bank <= '0;
                        if (!iAbort && !at_last) addr <= addr + ADDR_W'(1);
                    end else begin
                        bank <= bank + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.oRDEN   = (state == S_FETCH);
        bus.oRAddr  = addr;
        bus.oValid  = (state == S_SEND);
        bus.oData   = (state == S_SEND) ? hold[bank] : 32'd0;
        bus.oSOP    = (state == S_SEND) && (addr == '0) && (bank == 2'd0);
        bus.oEOP    = (state == S_SEND) && at_last && (bank == 2'd2);
        oBusy       = (state != S_IDLE);
        oStateReset = (state == S_DONE);
        dbg_state   = state;
    end

endmodule

// File: doc/adc_ocram_reader.md
Name: adc_ocram_reader

Overview:
Read-side counterpart of the ADC capture writer. After the writer raises its transmit-ready flag, this block reads the three packed 32-bit capture RAM banks from address 0 to iRecLength. It serialises each address into three 32-bit words on a valid/ready stream towards the HPS/transmit path, then pulses oStateReset so the writer re-arms.

Parameters:
ADDR_W, 13, RAM address width; must match writer address / iRecLength width
RD_LAT, 2, RAM read latency in clocks from oRDEN to iRAMData valid (legal 1..4)
CNT_W, 15, width of oWordCount; must hold 3*2^ADDR_W

Ports:
ocramCLK  in  1  single clock for all logic and the RAM read ports
iReset  in  1  asynchronous, active-high reset
iTransmitReady  in  1  writer's capture-complete flag (level)
iRecLength  in  ADDR_W  last address written by writer (inclusive)
iAbort  in  1  synchronous abort request
oRDEN  out  1  read enable, common to all 3 banks
oRAddr  out  ADDR_W  read address, common to all 3 banks
iRAMData  in  3x32  bank read data; [0],[1],[2] = banks 0..2
oData  out  32  stream data word
oValid  out  1  stream valid
iReady  in  1  stream ready from sink
oSOP  out  1  high with first word of a readout
oEOP  out  1  high with last word of a readout
oBusy  out  1  high in any state other than IDLE
oStateReset  out  1  one-cycle pulse to writer's state-reset input at end of readout
oWordCount  out  CNT_W  words accepted by sink in current/last readout

Behaviour:
- Async reset: state IDLE; oRDEN, oValid, oSOP, oEOP, oBusy, oStateReset = 0; oRAddr, oData, oWordCount, hold register, latency counter, bank index = 0.
- States: IDLE, FETCH, WAIT, SEND, DONE, HOLD.
- IDLE: on a rising edge of iTransmitReady (registered previous value 0, current 1):
  - latch iRecLength into lastAddr; clear addr, oWordCount, bank index;
  - set first-word flag; go to FETCH.
  - A level already high at reset release is not an edge.
- FETCH (1 cycle): oRDEN=1, oRAddr=addr; go to WAIT with latency counter = RD_LAT.
- WAIT: oRDEN=0; decrement counter. On the cycle iRAMData is valid (RD_LAT cycles after the FETCH cycle), capture all 96 bits into the hold register; go to SEND with bank index 0.
- SEND:
  - oValid=1, oData = hold[bank index].
  - oSOP=1 only on bank 0 of address 0 of a readout.
  - oEOP=1 only on bank 2 of address lastAddr.
  - Transfer occurs when oValid && iReady. While stalled, oData/oSOP/oEOP hold stable.
  - On transfer: oWordCount+1, bank index+1.
  - After bank 2: if addr==lastAddr go to DONE, else addr+1 and go to FETCH.
  - No prefetch. Per address: 1 + RD_LAT capture cycles + 3 send cycles (minimum).
- DONE (1 cycle): oValid=0, oStateReset=1; go to HOLD.
- HOLD: wait for iTransmitReady==0, then go to IDLE. This prevents re-reading the same capture.
- iAbort in FETCH/WAIT/SEND: go to DONE next cycle; oValid drops immediately.
  - An in-flight transfer in the abort cycle still counts.
  - No EOP is generated. oStateReset is still pulsed.
- iAbort in IDLE/DONE/HOLD is ignored.
- Boundaries:
  - iRecLength=0 gives exactly 3 words, with SOP and EOP on different words.
  - iRecLength=2^ADDR_W-1 reads the full RAM; oRAddr never wraps, and the final address is 2^ADDR_W-1.
  - Total words = 3*(lastAddr+1). Changes to iRecLength during a readout are ignored.
- Async reset mid-readout: immediate return to IDLE with no oStateReset pulse. Restart requires a new rising edge of iTransmitReady.

Test Plan:
1. RD_LAT=2, iRecLength=0, bank data A0/B0/C0, iReady=1 → words A0,B0,C0; SOP on A0, EOP on C0; oRDEN high 1 cycle at addr 0; oStateReset single pulse; oWordCount=3.
2. iRecLength=3, RAM[a][b]=a*16+b, iReady=1 → 12 words in order 0,1,2,16,17,18,...,50; each FETCH precedes its SEND by RD_LAT+1 cycles; oWordCount=12.
3. Same as 2 with pseudo-random iReady (30% low) → identical sequence; oData/oSOP/oEOP stable during every stall; oWordCount=12.
4. iTransmitReady held high after DONE for 50 cycles → stays in HOLD, no second oRDEN; low then high → new readout with SOP.
5. iAbort asserted while sending word 5 of 12 → oValid low next cycle, no EOP, one oStateReset pulse; async iReset mid-WAIT → all outputs 0, no pulse.
6. iRecLength=8191 → 24576 words; last oRAddr=8191, no wrap; EOP on word 24576; oWordCount=24576.
